// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Desc     : Shared configuration record, reset constants and legality check
//            for the programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Record fields are held at a fixed width wide enough for any CNT_W up to
    // 32. Narrower values are zero-extended, so the compares stay unsigned.
    localparam int C_CFG_W    = 32;
    localparam int C_DEF_DIV  = 42;
    localparam int C_DEF_HIGH = C_DEF_DIV / 2;

    typedef struct packed {
        logic [C_CFG_W-1:0] div;
        logic [C_CFG_W-1:0] high;
        logic [C_CFG_W-1:0] phase;
    } cfg_t;

    function automatic logic cfg_legal(
        input cfg_t        cfg,
        input int unsigned chan,
        input int unsigned num_chans
    );
        return (cfg.div >= C_CFG_W'(2))
            && (cfg.high >= C_CFG_W'(1))
            && (cfg.high < cfg.div)
            && (cfg.phase < cfg.div)
            && (chan < num_chans);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_chan
// Desc     : One divider channel: counter, shadow ratio/duty/phase registers,
//            apply-at-wrap update and saturating lock counter.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEF_DIV      = C_DEF_DIV,
    parameter int LOCK_PERIODS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_req,
    input  logic             apply_req,
    input  logic [CNT_W-1:0] new_div,
    input  logic [CNT_W-1:0] new_high,
    input  logic [CNT_W-1:0] new_phase,
    output logic             applied,
    output logic             outclk,
    output logic             ce,
    output logic             lock_sat
);

    localparam int               LOCK_W     = $clog2(LOCK_PERIODS + 1);
    localparam logic [CNT_W-1:0] C_RST_DIV  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] C_RST_HIGH = CNT_W'(DEF_DIV / 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [LOCK_W-1:0] C_LOCK_MAX = LOCK_W'(LOCK_PERIODS);
    localparam logic [LOCK_W-1:0] C_LOCK_ONE = LOCK_W'(1);

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_high;
    logic [CNT_W-1:0]  r_phase;
    logic [LOCK_W-1:0] r_lock;
    logic              r_outclk;
    logic              r_ce;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_wrap;

    // cnt+1 == div is the last cycle of the period; cnt never exceeds div-1,
    // so the increment cannot overflow.
    assign w_cnt_inc = r_cnt + C_CNT_ONE;
    assign w_wrap    = (w_cnt_inc == r_div);

    // A realign in the same cycle defers the update to the following wrap.
    assign applied   = apply_req && w_wrap && !sync_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_div    <= C_RST_DIV;
            r_high   <= C_RST_HIGH;
            r_phase  <= '0;
            r_lock   <= '0;
            r_outclk <= 1'b0;
            r_ce     <= 1'b0;
        end else begin
            r_outclk <= (r_cnt < r_high);
            r_ce     <= w_wrap;
            if (sync_req) begin
                r_cnt  <= r_phase;
                r_lock <= '0;
            end else if (w_wrap) begin
                r_cnt <= '0;
                if (apply_req) begin
                    r_div   <= new_div;
                    r_high  <= new_high;
                    r_phase <= new_phase;
                    r_lock  <= '0;
                end else if (r_lock != C_LOCK_MAX) begin
                    r_lock <= r_lock + C_LOCK_ONE;
                end
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign outclk   = r_outclk;
    assign ce       = r_ce;
    assign lock_sat = (r_lock == C_LOCK_MAX);

endmodule
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen
// Desc     : Multi-channel programmable clock generator with single-slot
//            config handshake, validation, realign and lock indication.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CLKS     = 4,
    parameter int CNT_W        = 16,
    parameter int DEF_DIV      = C_DEF_DIV,
    parameter int LOCK_PERIODS = 4,
    localparam int CHAN_W      = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CNT_W-1:0]    cfg_phase,
    output logic                cfg_err,
    input  logic                sync_req,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] ce,
    output logic                locked
);

    cfg_t                w_req;
    logic                w_accept;
    logic                w_legal;
    logic                w_apply_any;
    logic [NUM_CLKS-1:0] w_applied;
    logic [NUM_CLKS-1:0] w_lock_sat;

    logic                r_pend_valid;
    logic [CHAN_W-1:0]   r_pend_chan;
    logic [CNT_W-1:0]    r_pend_div;
    logic [CNT_W-1:0]    r_pend_high;
    logic [CNT_W-1:0]    r_pend_phase;
    logic                r_cfg_err;
    logic                r_locked;

    assign w_req.div   = C_CFG_W'(cfg_div);
    assign w_req.high  = C_CFG_W'(cfg_high);
    assign w_req.phase = C_CFG_W'(cfg_phase);

    assign w_accept    = cfg_valid && !r_pend_valid;
    assign w_legal     = cfg_legal(w_req, 32'(cfg_chan), NUM_CLKS);
    assign w_apply_any = |w_applied;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_chan  <= '0;
            r_pend_div   <= '0;
            r_pend_high  <= '0;
            r_pend_phase <= '0;
            r_cfg_err    <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && !w_legal;
            // Lock falls immediately on any retune or realign rather than
            // waiting for the per-channel counters to clear.
            r_locked  <= (&w_lock_sat) && !w_apply_any && !sync_req;
            if (w_accept && w_legal) begin
                r_pend_valid <= 1'b1;
                r_pend_chan  <= cfg_chan;
                r_pend_div   <= cfg_div;
                r_pend_high  <= cfg_high;
                r_pend_phase <= cfg_phase;
            end else if (w_apply_any) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CLKS; gi++) begin : g_chan
        clk_div_chan #(
            .CNT_W        (CNT_W),
            .DEF_DIV      (DEF_DIV),
            .LOCK_PERIODS (LOCK_PERIODS)
        ) u_chan (
            .clk       (refclk),
            .rst       (rst),
            .sync_req  (sync_req),
            .apply_req (r_pend_valid && (r_pend_chan == CHAN_W'(gi))),
            .new_div   (r_pend_div),
            .new_high  (r_pend_high),
            .new_phase (r_pend_phase),
            .applied   (w_applied[gi]),
            .outclk    (outclk[gi]),
            .ce        (ce[gi]),
            .lock_sat  (w_lock_sat[gi])
        );
    end

    assign cfg_ready = !r_pend_valid;
    assign cfg_err   = r_cfg_err;
    assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_gen
// Desc     : Directed self-checking bench for clk_div_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_chan = '0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_high = '0;
    logic [15:0] cfg_phase = '0;
    logic        cfg_err;
    logic        sync_req = 1'b0;
    logic [3:0]  outclk;
    logic [3:0]  ce;
    logic        locked;

    int errors = 0;
    int checks = 0;

    clk_div_gen dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .sync_req  (sync_req),
        .outclk    (outclk),
        .ce        (ce),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input int ch, input int dv, input int hi, input int ph);
        cfg_chan  = 2'(ch);
        cfg_div   = 16'(dv);
        cfg_high  = 16'(hi);
        cfg_phase = 16'(ph);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ce(input int ch, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (ce[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_locked(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (locked) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (cfg_ready) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int hi;
        int first_ce;
        int ce_pos;
        int bad_div  [3] = '{5, 8, 8};
        int bad_high [3] = '{5, 0, 2};
        int bad_phase[3] = '{0, 0, 8};

        // Reset values and default 42-cycle operation
        repeat (3) tick();
        chk("rst_outclk", outclk, 0);
        chk("rst_ce", ce, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_err", cfg_err, 0);

        rst = 1'b0;
        hi = 0;
        first_ce = -1;
        for (int k = 1; k <= 42; k++) begin
            tick();
            if (k == 1) chk("start_outclk", outclk, 4'hF);
            if (outclk[0]) hi++;
            if (ce != 0 && first_ce < 0) first_ce = k;
        end
        chk("def_high_cycles", hi, 21);
        chk("def_first_ce", first_ce, 42);
        chk("def_ce_all", ce, 4'hF);
        wait_locked(200, n);
        chk("def_lock_time", n, 127);

        // Mid-period retune of ch1: old period finishes first
        send_cfg(1, 10, 3, 0);
        chk("cfg_busy", cfg_ready, 0);
        wait_ce(1, 100, n);
        chk("old_period_end", n, 40);
        chk("ready_at_apply", cfg_ready, 1);
        chk("lock_drop_apply", locked, 0);
        hi = 0;
        ce_pos = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (outclk[1]) hi++;
            if (ce[1] && ce_pos < 0) ce_pos = k;
        end
        chk("new_high_cycles", hi, 3);
        chk("new_period", ce_pos, 10);
        wait_locked(100, n);
        chk("relock_time", n, 31);

        // Illegal configurations are rejected without state change
        for (int v = 0; v < 3; v++) begin
            send_cfg(1, bad_div[v], bad_high[v], bad_phase[v]);
            chk("bad_err_pulse", cfg_err, 1);
            chk("bad_ready", cfg_ready, 1);
            tick();
            chk("bad_err_clear", cfg_err, 0);
        end
        wait_ce(1, 20, n);
        wait_ce(1, 20, n);
        chk("bad_period_kept", n, 10);
        chk("bad_lock_kept", locked, 1);

        // Phase offset after realign
        send_cfg(0, 4, 2, 0);
        wait_ready(100, n);
        chk("apply_ch0", n > 0, 1);
        send_cfg(1, 4, 2, 2);
        wait_ready(100, n);
        chk("apply_ch1", n > 0, 1);
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        chk("sync_lock_low", locked, 0);
        wait_ce(1, 20, n);
        chk("ch1_lead", n, 2);
        wait_ce(0, 20, n);
        chk("ch0_lag", n, 2);

        // Realign coinciding with ch2 wrap defers its pending update
        send_cfg(2, 6, 1, 0);
        repeat (36) tick();
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        chk("ch2_wrap_seen", ce[2], 1);
        chk("sync_keeps_pend", cfg_ready, 0);
        wait_ce(2, 100, n);
        chk("ch2_deferred", n, 42);
        chk("ch2_applied", cfg_ready, 1);
        wait_ce(2, 20, n);
        chk("ch2_new_period", n, 6);

        // Reset discards a pending update
        send_cfg(3, 8, 4, 0);
        chk("pend_before_rst", cfg_ready, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_outclk", outclk, 0);
        chk("mid_rst_ce", ce, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        chk("mid_rst_err", cfg_err, 0);
        rst = 1'b0;
        wait_ce(3, 100, n);
        chk("ch3_default_kept", n, 42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
